// File: rtl/align_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : align_sequencer
//  Description : Floating-point operand alignment sequencer. Accepts a pair
//                of (biased exponent, stored mantissa) operands, picks the
//                operand with the larger exponent, right-shifts the hidden-bit
//                extended mantissa of the other one by the exponent
//                difference, and presents the result with round and sticky
//                bits through a valid/ready handshake.
//
//  Ports
//    clk            : single clock, rising-edge active
//    rst_n          : asynchronous active-low reset
//    in_valid/ready : operand handshake (ready only while idle)
//    a_exp, a_mant  : operand A (biased exponent, stored mantissa)
//    b_exp, b_mant  : operand B (biased exponent, stored mantissa)
//    out_valid/ready: result handshake
//    big_exp        : exponent of the larger-exponent operand
//    big_mant       : unshifted mantissa of the larger-exponent operand
//    small_mant     : aligned mantissa of the smaller-exponent operand
//    R, S           : round and sticky bits of the alignment shift
//    swapped        : 1 when B had the strictly larger exponent
//    done_count     : number of results handed off (wraps at 256)
//
//  Revision    : 1.0  initial release
// ============================================================================
module align_sequencer #(
  parameter int N   = 23,
  parameter int EXP = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [EXP-1:0] a_exp,
  input  logic [EXP-1:0] b_exp,
  input  logic [N-1:0]   a_mant,
  input  logic [N-1:0]   b_mant,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EXP-1:0] big_exp,
  output logic [N-1:0]   big_mant,
  output logic [N-1:0]   small_mant,
  output logic           R,
  output logic           S,
  output logic           swapped,
  output logic [7:0]     done_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    SHIFT = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Captured operands
  logic [EXP-1:0] a_exp_q, b_exp_q;
  logic [N-1:0]   a_mant_q, b_mant_q;

  // Compare-stage results
  logic [EXP-1:0] d_q;
  logic           swp_q;
  logic [EXP-1:0] bexp_q;
  logic [N-1:0]   bmant_q;
  logic [N-1:0]   smant_q;

  // Output registers; loaded only when entering OUT so the visible
  // fields hold their previous values during CMP and SHIFT.
  logic [EXP-1:0] big_exp_q;
  logic [N-1:0]   big_mant_q;
  logic [N-1:0]   small_mant_q;
  logic           r_bit_q, s_bit_q, swapped_q;
  logic [7:0]     done_count_q, done_count_d;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      done_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      done_count_q <= done_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    done_count_d = done_count_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CMP;
      end
      CMP:   state_d = SHIFT;
      SHIFT: state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done_count_d = done_count_q + 8'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Alignment shifter
  // The hidden-bit mantissa is placed at the top of a double-width vector so
  // that after the shift the upper N+1 bits are {small_mant, R} and every bit
  // that fell below R lands in the lower half for the sticky OR. Shifting by
  // d-1 (not d) keeps the R position directly below small_mant.
  // --------------------------------------------------------------------------
  logic [2*N+1:0] shift_wide;
  logic [N-1:0]   sh_mant;
  logic           sh_r, sh_s;

  assign shift_wide = {1'b1, smant_q, {(N+1){1'b0}}} >> (d_q - EXP'(1));

  always_comb begin
    sh_mant = '0;
    sh_r    = 1'b0;
    sh_s    = 1'b0;
    if (d_q == '0) begin
      sh_mant = smant_q;
    end else if (32'(d_q) >= N + 2) begin
      // Whole operand (including hidden bit) lies below the R position
      sh_s = 1'b1;
    end else begin
      sh_mant = shift_wide[2*N+1:N+2];
      sh_r    = shift_wide[N+1];
      sh_s    = |shift_wide[N:0];
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_exp_q      <= '0;
      b_exp_q      <= '0;
      a_mant_q     <= '0;
      b_mant_q     <= '0;
      d_q          <= '0;
      swp_q        <= 1'b0;
      bexp_q       <= '0;
      bmant_q      <= '0;
      smant_q      <= '0;
      big_exp_q    <= '0;
      big_mant_q   <= '0;
      small_mant_q <= '0;
      r_bit_q      <= 1'b0;
      s_bit_q      <= 1'b0;
      swapped_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_exp_q  <= a_exp;
            b_exp_q  <= b_exp;
            a_mant_q <= a_mant;
            b_mant_q <= b_mant;
          end
        end
        CMP: begin
          // Ties keep A as the big operand
          if (b_exp_q > a_exp_q) begin
            swp_q   <= 1'b1;
            d_q     <= b_exp_q - a_exp_q;
            bexp_q  <= b_exp_q;
            bmant_q <= b_mant_q;
            smant_q <= a_mant_q;
          end else begin
            swp_q   <= 1'b0;
            d_q     <= a_exp_q - b_exp_q;
            bexp_q  <= a_exp_q;
            bmant_q <= a_mant_q;
            smant_q <= b_mant_q;
          end
        end
        SHIFT: begin
          big_exp_q    <= bexp_q;
          big_mant_q   <= bmant_q;
          small_mant_q <= sh_mant;
          r_bit_q      <= sh_r;
          s_bit_q      <= sh_s;
          swapped_q    <= swp_q;
        end
        default: ;
      endcase
    end
  end

  assign big_exp    = big_exp_q;
  assign big_mant   = big_mant_q;
  assign small_mant = small_mant_q;
  assign R          = r_bit_q;
  assign S          = s_bit_q;
  assign swapped    = swapped_q;
  assign done_count = done_count_q;

endmodule
`default_nettype wire

// File: tb/tb_align_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_align_sequencer
//  Description : Self-checking bench for align_sequencer. A behavioural model
//                computes the alignment result with integer arithmetic and
//                tracks handshake timing; a compare process checks every
//                cycle, and directed vectors carry hand-computed literals.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_align_sequencer;

  localparam int N   = 23;
  localparam int EXP = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [EXP-1:0] a_exp = '0, b_exp = '0;
  logic [N-1:0]   a_mant = '0, b_mant = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [EXP-1:0] big_exp;
  logic [N-1:0]   big_mant, small_mant;
  logic           R, S, swapped;
  logic [7:0]     done_count;

  int n_checks = 0;
  int n_err    = 0;
  logic started = 1'b0;

  align_sequencer #(.N(N), .EXP(EXP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_exp(a_exp), .b_exp(b_exp), .a_mant(a_mant), .b_mant(b_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .big_exp(big_exp), .big_mant(big_mant), .small_mant(small_mant),
    .R(R), .S(S), .swapped(swapped), .done_count(done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [EXP-1:0] bexp;
    logic [N-1:0]   bmant;
    logic [N-1:0]   sm;
    logic           r;
    logic           s;
    logic           sw;
  } res_t;

  function automatic res_t calc(input logic [EXP-1:0] ae, input logic [N-1:0] am,
                                input logic [EXP-1:0] be, input logic [N-1:0] bm);
    res_t x;
    int d;
    logic [N-1:0] m;
    longint full, sh;
    x = '0;
    x.sw = (be > ae);
    if (x.sw) begin
      x.bexp = be; x.bmant = bm; m = am; d = int'(be) - int'(ae);
    end else begin
      x.bexp = ae; x.bmant = am; m = bm; d = int'(ae) - int'(be);
    end
    if (d == 0) begin
      x.sm = m;
    end else if (d <= N + 1) begin
      full = (longint'(1) << N) | longint'(m);
      sh   = full >> (d - 1);
      x.sm = sh[N:1];
      x.r  = sh[0];
      x.s  = (full & ((longint'(1) << (d - 1)) - 1)) != 0;
    end else begin
      x.s  = 1'b1;
    end
    return x;
  endfunction

  int   m_phase;   // cycles elapsed since acceptance; 0 = idle, 3 = presenting
  res_t m_pend, m_vis;
  logic [7:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_pend  <= '0;
      m_vis   <= '0;
      m_cnt   <= 8'd0;
    end else begin
      if (m_phase == 0) begin
        if (in_valid) begin
          m_pend  <= calc(a_exp, a_mant, b_exp, b_mant);
          m_phase <= 1;
        end
      end else if (m_phase < 3) begin
        if (m_phase == 2) m_vis <= m_pend;
        m_phase <= m_phase + 1;
      end else if (out_ready) begin
        m_cnt   <= m_cnt + 8'd1;
        m_phase <= 0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready",   in_ready,   m_phase == 0);
      chk("out_valid",  out_valid,  m_phase == 3);
      chk("done_count", done_count, m_cnt);
      chk("big_exp",    big_exp,    m_vis.bexp);
      chk("big_mant",   big_mant,   m_vis.bmant);
      chk("small_mant", small_mant, m_vis.sm);
      chk("R",          R,          m_vis.r);
      chk("S",          S,          m_vis.s);
      chk("swapped",    swapped,    m_vis.sw);
    end
  end

  // --------------------------------------------------------------------------
  // Directed operation with hand-computed expectations
  // --------------------------------------------------------------------------
  task automatic run_op(input logic [EXP-1:0] ae, input logic [N-1:0] am,
                        input logic [EXP-1:0] be, input logic [N-1:0] bm,
                        input int hold,
                        input logic e_sw, input logic [EXP-1:0] e_bexp,
                        input logic [N-1:0] e_bmant, input logic [N-1:0] e_sm,
                        input logic e_r, input logic e_s);
    logic [7:0] cnt0;
    for (int i = 0; i < 8 && !in_ready; i++) @(negedge clk);
    chk("in_ready_wait", in_ready, 1'b1);
    a_exp = ae; a_mant = am; b_exp = be; b_mant = bm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !out_valid; i++) @(negedge clk);
    chk("out_valid_wait", out_valid, 1'b1);
    chk("lit_swapped",  swapped,    e_sw);
    chk("lit_big_exp",  big_exp,    e_bexp);
    chk("lit_big_mant", big_mant,   e_bmant);
    chk("lit_small",    small_mant, e_sm);
    chk("lit_R",        R,          e_r);
    chk("lit_S",        S,          e_s);
    cnt0 = done_count;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid,  1'b1);
      chk("hold_ready", in_ready,   1'b0);
      chk("hold_count", done_count, cnt0);
      chk("hold_small", small_mant, e_sm);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_ready", in_ready,   1'b1);
    chk("post_count", done_count, cnt0 + 8'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  in_ready,   1'b1);
    chk("rst_out_valid", out_valid,  1'b0);
    chk("rst_count",     done_count, 8'd0);
    chk("rst_small",     small_mant, '0);
    chk("rst_big_exp",   big_exp,    '0);
    rst_n   = 1'b1;
    started = 1'b1;

    // d=2, small=B
    run_op(8'd130, 23'd0, 8'd128, 23'd0, 0, 1'b0, 8'd130, 23'd0, 23'h200000, 1'b0, 1'b0);
    // equal exponents, held for 5 cycles
    run_op(8'd100, 23'd5, 8'd100, 23'd7, 5, 1'b0, 8'd100, 23'd5, 23'd7, 1'b0, 1'b0);
    // B larger, d=40 -> everything into sticky
    run_op(8'd10, 23'h7FFFFF, 8'd50, 23'd9, 0, 1'b1, 8'd50, 23'd9, 23'd0, 1'b0, 1'b1);
    // d=2 with a discarded low bit
    run_op(8'd3, 23'd1, 8'd1, 23'd1, 1, 1'b0, 8'd3, 23'd1, 23'h200000, 1'b0, 1'b1);
    // d=1: R is the old LSB, sticky empty
    run_op(8'd5, 23'd0, 8'd4, 23'd3, 0, 1'b0, 8'd5, 23'd0, 23'h400001, 1'b1, 1'b0);
    // d=1 with B larger
    run_op(8'd7, 23'd0, 8'd8, 23'h123, 0, 1'b1, 8'd8, 23'h123, 23'h400000, 1'b0, 1'b0);
    // d=N+1: hidden bit lands in R
    run_op(8'd30, 23'd0, 8'd6, 23'd1, 0, 1'b0, 8'd30, 23'd0, 23'd0, 1'b1, 1'b1);
    // d=N+2: hidden bit below R
    run_op(8'd31, 23'd0, 8'd6, 23'd0, 0, 1'b0, 8'd31, 23'd0, 23'd0, 1'b0, 1'b1);

    // Reset pulsed while in SHIFT
    a_exp = 8'd20; a_mant = 23'd1; b_exp = 8'd18; b_mant = 23'd2;
    in_valid = 1'b1;
    @(negedge clk);          // CMP
    in_valid = 1'b0;
    @(negedge clk);          // SHIFT
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  in_ready,   1'b1);
    chk("mid_rst_out_valid", out_valid,  1'b0);
    chk("mid_rst_count",     done_count, 8'd0);
    chk("mid_rst_small",     small_mant, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("after_rst_valid", out_valid, 1'b0);
    end

    // Back-to-back operations to wrap the counter; in_valid stays high
    // through CMP/SHIFT/OUT with changing operands that must be ignored.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 1; k <= 1024; k++) begin
      a_exp  = EXP'($urandom_range(0, 255));
      b_exp  = EXP'($urandom_range(0, 255));
      a_mant = N'($urandom);
      b_mant = N'($urandom);
      @(negedge clk);
      if (k == 1020) chk("count_255", done_count, 8'd255);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("count_wrap", done_count, 8'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
